// File: rtl/fp_div.sv
// Iterative radix-2 restoring floating-point divider, one quotient bit per clock.
// The result is truncated and zero exponents flush to zero; there is no Inf/NaN or range detection.
module fp_div #(
   parameter int FP_WIDTH  = 32,
   parameter int EXP_WIDTH = 8,
   parameter int MAN_WIDTH = 23
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [FP_WIDTH-1:0] IN1,
   input  logic [FP_WIDTH-1:0] IN2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [FP_WIDTH-1:0] OUT
);

   localparam int RW   = MAN_WIDTH + 2;
   localparam int CW   = $clog2(MAN_WIDTH + 2);
   localparam int XW   = EXP_WIDTH + 2;
   localparam int BIAS = 2**(EXP_WIDTH-1) - 1;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CW-1:0]          r_cnt;
   logic [RW-1:0]          r_rem;
   logic [MAN_WIDTH:0]     r_div;
   logic [RW-2:0]          r_q;
   logic                   r_sign;
   logic [EXP_WIDTH-1:0]   r_ea;
   logic [EXP_WIDTH-1:0]   r_eb;
   logic                   r_za;
   logic                   r_zb;
   logic [FP_WIDTH-1:0]    r_out;

   logic                   w_accept;
   logic                   w_last;
   logic                   w_ge;
   logic [MAN_WIDTH:0]     w_rsub;
   logic [RW-1:0]          w_rnext;
   logic [RW-1:0]          w_qnext;
   logic [MAN_WIDTH-1:0]   w_man;
   logic [EXP_WIDTH-1:0]   w_exp;
   logic [FP_WIDTH-1:0]    w_result;

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_last   = (r_cnt == CW'(MAN_WIDTH + 1));

   // R - D fits in MAN_WIDTH+1 bits whenever R >= D, so the top remainder bit can be dropped.
   assign w_ge    = (r_rem >= {1'b0, r_div});
   assign w_rsub  = r_rem[RW-2:0] - r_div;
   assign w_rnext = w_ge ? {w_rsub, 1'b0} : {r_rem[RW-2:0], 1'b0};
   assign w_qnext = {r_q, w_ge};

   assign w_man = w_qnext[RW-1] ? w_qnext[MAN_WIDTH:1] : w_qnext[MAN_WIDTH-1:0];
   assign w_exp = EXP_WIDTH'({2'b00, r_ea} - {2'b00, r_eb} + XW'(BIAS)
                             - {{(XW-1){1'b0}}, ~w_qnext[RW-1]});

   always_comb begin
      w_result = {r_sign, w_exp, w_man};
      if (r_zb)
         w_result = {r_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      else if (r_za)
         w_result = {r_sign, {(FP_WIDTH-1){1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = BUSY;
         BUSY:    if (w_last)   w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_rem  <= '0;
         r_div  <= '0;
         r_q    <= '0;
         r_sign <= 1'b0;
         r_ea   <= '0;
         r_eb   <= '0;
         r_za   <= 1'b0;
         r_zb   <= 1'b0;
         r_out  <= '0;
      end else if (w_accept) begin
         r_sign <= IN1[FP_WIDTH-1] ^ IN2[FP_WIDTH-1];
         r_ea   <= IN1[FP_WIDTH-2 -: EXP_WIDTH];
         r_eb   <= IN2[FP_WIDTH-2 -: EXP_WIDTH];
         r_za   <= (IN1[FP_WIDTH-2 -: EXP_WIDTH] == '0);
         r_zb   <= (IN2[FP_WIDTH-2 -: EXP_WIDTH] == '0);
         r_rem  <= {2'b01, IN1[MAN_WIDTH-1:0]};
         r_div  <= {1'b1, IN2[MAN_WIDTH-1:0]};
         r_q    <= '0;
         r_cnt  <= '0;
      end else if (r_state == BUSY) begin
         r_rem <= w_rnext;
         r_q   <= w_qnext[RW-2:0];
         r_cnt <= r_cnt + 1'b1;
         if (w_last)
            r_out <= w_result;
      end
   end

   assign OUT = r_out;

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: expected quotients come from a one-shot integer-division model.
`timescale 1ns/1ps
module tb_fp_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] IN1;
   logic [31:0] IN2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] OUT;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb[$];

   fp_div #(.FP_WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .IN1(IN1), .IN2(IN2), .out_valid(out_valid), .out_ready(out_ready), .OUT(OUT)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int ea, eb, e;
      longint unsigned ma, mb, q;
      logic [22:0] m;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (eb == 0) return {s, 8'hFF, 23'h0};
      if (ea == 0) return {s, 31'h0};
      ma = {40'h0, 1'b1, a[22:0]};
      mb = {40'h0, 1'b1, b[22:0]};
      q  = (ma << 24) / mb;
      if (q >= (64'd1 << 24)) begin
         m = q[23:1];
         e = ea - eb + 127;
      end else begin
         m = q[22:0];
         e = ea - eb + 126;
      end
      return {s, e[7:0], m};
   endfunction

   // Issue one operation, check latency and BUSY handshake, optionally hold backpressure, then retire.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] req,
                         input bit use_req, input int hold, input string name);
      int lat;
      bit busy_bad;
      bit stable_bad;
      logic [31:0] held;
      logic [31:0] exp_v;
      @(negedge clk);
      IN1 = a; IN2 = b; in_valid = 1'b1; out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL %s_ready_before act=%b req=1", name, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back(ref_div(a, b));
      lat = 0; busy_bad = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (in_ready !== 1'b0) busy_bad = 1;
         IN1 = $urandom; IN2 = $urandom;
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (lat != 25) begin
         bad++; $display("FAIL %s_latency act=%0d req=25", name, lat);
      end
      total++;
      if (busy_bad) begin
         bad++; $display("FAIL %s_in_ready_busy act=1 req=0", name);
      end
      held = OUT; stable_bad = 0;
      for (int i = 0; i < hold; i++) begin
         IN1 = $urandom; IN2 = $urandom; in_valid = 1'b1;
         @(posedge clk); #1;
         if (OUT !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable_bad = 1;
      end
      in_valid = 1'b0;
      if (hold > 0) begin
         total++;
         if (stable_bad) begin
            bad++; $display("FAIL %s_backpressure act=%h req=%h", name, OUT, held);
         end
      end
      exp_v = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
      total++;
      if (OUT !== exp_v) begin
         bad++; $display("FAIL %s_model act=%h req=%h", name, OUT, exp_v);
      end
      if (use_req) begin
         total++;
         if (OUT !== req) begin
            bad++; $display("FAIL %s_value act=%h req=%h", name, OUT, req);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL %s_retire act=%b%b req=10", name, in_ready, out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      IN1 = 32'h40C00000; IN2 = 32'h40000000;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || OUT !== 32'h0) begin
         bad++; $display("FAIL reset_state act=%b%b_%h req=10_00000000", in_ready, out_valid, OUT);
      end
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_idle act=%b req=1", in_ready);
      end
   endtask

   task automatic test_basic();
      run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1, 0, "div_6_2");
      run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1, 0, "div_1_3");
      run_op(32'hBFC00000, 32'h3F000000, 32'hC0400000, 1, 0, "div_m15_05");
   endtask

   task automatic test_special();
      run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0, "div_by_zero");
      run_op(32'h00000000, 32'hC0000000, 32'h80000000, 1, 0, "zero_div");
   endtask

   task automatic test_backpressure();
      run_op(32'h41200000, 32'h40800000, 32'h40200000, 1, 10, "bp_10_4");
   endtask

   task automatic test_reset_busy();
      @(negedge clk);
      IN1 = 32'h3F800000; IN2 = 32'h40400000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || OUT !== 32'h0) begin
         bad++; $display("FAIL rst_busy act=%b%b_%h req=01_00000000", out_valid, in_ready, OUT);
      end
      run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1, 0, "after_rst");
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      for (int i = 0; i < 6; i++) begin
         a = {1'($urandom), 8'($urandom_range(90, 160)), 23'($urandom)};
         b = {1'($urandom), 8'($urandom_range(90, 160)), 23'($urandom)};
         run_op(a, b, 32'h0, 0, 0, "rand");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_special();
      test_backpressure();
      test_reset_busy();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_div.md
# fp_div

Iterative IEEE-style floating-point divider, the inverse-operation companion to the combinational Booth/CSA multiplier `fp_mul` in the fused-FP datapath. It computes `IN1 / IN2` with a radix-2 restoring mantissa divider, one quotient bit per clock. It uses the same format parameters, the same hidden-bit handling and the same truncating (round-toward-zero) result convention as `fp_mul`. A valid/ready handshake on both sides lets it sit behind an operand queue and in front of the result writeback.

## Interface

Parameters:

- `FP_WIDTH`, default 32: total word width.
- `EXP_WIDTH`, default 8: exponent field width. Bias = 2^(EXP_WIDTH-1)-1.
- `MAN_WIDTH`, default 23: stored mantissa width. The hidden 1 is implicit.

Ports:

- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: operands valid.
- `in_ready`, output, 1: divider idle, operands accepted this cycle if `in_valid`.
- `IN1`, input, FP_WIDTH: dividend.
- `IN2`, input, FP_WIDTH: divisor.
- `out_valid`, output, 1: `OUT` holds a result.
- `out_ready`, input, 1: consumer takes the result.
- `OUT`, output, FP_WIDTH: quotient, registered.

## Operation

- States:
  - IDLE: reset state.
  - BUSY: iterate.
  - DONE: result held.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE). Both are decoded from state registers only, with no combinational path from inputs.
- IDLE -> BUSY on `in_valid && in_ready`. That edge:
  - captures sign = `IN1[FP_WIDTH-1] ^ IN2[FP_WIDTH-1]`;
  - captures both exponent fields;
  - loads remainder R = {1'b1, IN1 mantissa} (MAN_WIDTH+2 bits, zero-extended);
  - loads divisor D = {1'b1, IN2 mantissa};
  - clears the quotient shift register Q (MAN_WIDTH+2 bits) and the iteration counter.
- BUSY, each edge:
  - if R >= D: shift 1 into Q LSB and set R = (R - D) << 1;
  - else: shift 0 into Q and set R = R << 1;
  - increment the counter.
  - After MAN_WIDTH+2 iterations, go to DONE and write `OUT` on the same edge.
- Result formation, with Q[MAN_WIDTH+1] the integer bit:
  - Q[MAN_WIDTH+1] = 1: mantissa = Q[MAN_WIDTH:1], exp = EA - EB + bias.
  - Q[MAN_WIDTH+1] = 0: mantissa = Q[MAN_WIDTH-1:0], exp = EA - EB + bias - 1.
  - Exponent math uses EXP_WIDTH+2 bits internally and the result keeps the low EXP_WIDTH bits. There is no overflow or underflow detection, matching `fp_mul`.
  - Truncation only. The remainder is discarded.
- Zero handling (exponent field 0 means zero; denormals flush to zero):
  - IN2 exp == 0: `OUT` = {sign, all-ones exp, zero mantissa} (±Inf).
  - else if IN1 exp == 0: `OUT` = {sign, zeros} (±0).
  - Special cases take the same full latency as normal operands.
- Inf/NaN inputs are not detected. They are divided as ordinary normals.
- DONE -> IDLE on `out_ready`. `OUT` holds its value until the next DONE entry.
- No new operand is accepted in the same cycle a result is taken. New operands are accepted only in IDLE.

## Timing

- Reset (`rst` high at an edge): state = IDLE, `out_valid` = 0, `in_ready` = 1 after the edge, `OUT` = 0, counter/Q/R = 0. `in_valid` is ignored in any cycle where `rst` is high.
- Reset mid-BUSY or mid-DONE: the operation is aborted and no result is ever presented. The next edge behaves as a fresh IDLE.
- Latency: acceptance at edge k gives `out_valid` = 1 after edge k + MAN_WIDTH + 2 (k+25 by default).
- Minimum issue interval: MAN_WIDTH+4 cycles (accept, 25 BUSY cycles, 1 DONE cycle, 1 IDLE cycle).
- Backpressure: `OUT` and `out_valid` stay stable while `out_ready` = 0, and `in_ready` stays 0.
- Changes on `IN1`/`IN2` after acceptance have no effect.

## Test plan

- 0x40C00000 / 0x40000000 (6.0/2.0) -> `OUT` = 0x40400000.
  - `out_valid` rises exactly 25 cycles after the accept edge.
  - `in_ready` is 0 throughout BUSY.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA, which exercises truncation and the Q[24] = 0 normalization path.
- 0xBFC00000 / 0x3F000000 (-1.5/0.5) -> 0xC0400000.
- Special cases:
  - 0x3F800000 / 0x00000000 -> 0x7F800000.
  - 0x00000000 / 0xC0000000 -> 0x80000000.
  - Both take 25 cycles.
- Backpressure: hold `out_ready` = 0 for 10 cycles after `out_valid` rises.
  - `OUT` and `out_valid` stay stable and `in_ready` stays 0.
  - Toggling `IN1`/`IN2` changes nothing.
  - After `out_ready` = 1 for one cycle, `in_ready` = 1 on the next cycle.
- Reset in BUSY: assert `rst` for 1 cycle at iteration 10.
  - After that edge, `out_valid` = 0, `in_ready` = 1 and `OUT` = 0.
  - A following 6.0/2.0 request returns 0x40400000 with the full 25-cycle latency.
